// File: rtl/subtraction_unit_if.sv
// Operand/result bundle for subtraction_unit.
// Signal names match the original flat port list so integrators can map one-to-one.
interface subtraction_unit_if #(
  parameter int unsigned WIDTH = 4
);
  // Request side, driven by the producer of operands
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BorrowIN;
  logic             ovf_clr;

  // Result side, driven by the subtractor
  logic             out_valid;
  logic [WIDTH-1:0] Y;
  logic             BorrowOUT;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             ovf_sticky;

  modport master (
    output in_valid, A, B, BorrowIN, ovf_clr,
    input  out_valid, Y, BorrowOUT, overflow, zero, negative, ovf_sticky
  );

  modport slave (
    input  in_valid, A, B, BorrowIN, ovf_clr,
    output out_valid, Y, BorrowOUT, overflow, zero, negative, ovf_sticky
  );
endinterface

// File: rtl/subtraction_unit.sv
// Registered WIDTH-bit subtractor: Y = A - B - BorrowIN, one-cycle latency.
// Flags: BorrowOUT (unsigned), overflow (two's complement), zero, negative,
// plus a sticky overflow bit cleared by ovf_clr (a new overflow wins the same cycle).
// Optional macro SUB_SATURATE_EN: on overflow Y clamps to max-positive / min-negative
// depending on the sign of A; overflow/BorrowOUT/ovf_sticky still describe the raw result.
module subtraction_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  subtraction_unit_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_y_raw;
  logic [WIDTH-1:0] w_y;
  logic             w_borrow;
  logic             w_ovf;
  logic             w_zero;
  logic             w_neg;
  logic             w_accept;

  logic [WIDTH-1:0] r_y;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_zero;
  logic             r_neg;
  logic             r_valid;
  logic             r_sticky;

  assign w_accept = bus.in_valid;

  // Extended-width difference: the extra top bit is the unsigned borrow-out
  always_comb begin
    w_diff   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, bus.BorrowIN};
    w_y_raw  = w_diff[WIDTH-1:0];
    w_borrow = w_diff[WIDTH];
    w_ovf    = (bus.A[MSB] != bus.B[MSB]) && (w_y_raw[MSB] != bus.A[MSB]);
  end

`ifdef SUB_SATURATE_EN
  // Clamp towards the sign of the minuend when the signed result overflowed
  always_comb begin
    w_y = w_y_raw;
    if (w_ovf) begin
      if (bus.A[MSB]) begin
        w_y = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_y = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  // Plain modulo-2^WIDTH result
  always_comb begin
    w_y = w_y_raw;
  end
`endif

  // zero/negative follow the value that will actually be registered
  always_comb begin
    w_zero = (w_y == '0);
    w_neg  = w_y[MSB];
  end

  // Result register: loads on accepted operations, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y      <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_y      <= w_y;
        r_borrow <= w_borrow;
        r_ovf    <= w_ovf;
        r_zero   <= w_zero;
        r_neg    <= w_neg;
      end
    end
  end

  // Sticky overflow: set by an accepted overflow, which takes priority over ovf_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_accept && w_ovf) begin
      r_sticky <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.Y          = r_y;
  assign bus.BorrowOUT  = r_borrow;
  assign bus.overflow   = r_ovf;
  assign bus.zero       = r_zero;
  assign bus.negative   = r_neg;
  assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_subtraction_unit.sv
// Self-checking bench for subtraction_unit: integer-arithmetic reference model,
// a per-cycle compare process, and directed vectors with literal expectations.
module tb_subtraction_unit;

  localparam int W    = 4;
  localparam int MOD  = 1 << W;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  subtraction_unit_if #(.WIDTH(W)) bus ();

  subtraction_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_y      = 0;
  int m_bo     = 0;
  int m_ovf    = 0;
  int m_zero   = 0;
  int m_neg    = 0;
  int m_valid  = 0;
  int m_sticky = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: evaluates the arithmetic rules on plain integers at each clock edge
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_y = 0; m_bo = 0; m_ovf = 0; m_zero = 0; m_neg = 0; m_valid = 0; m_sticky = 0;
      end else if (bus.in_valid) begin
        int a, b, bi, d, yw, amsb, bmsb, ov, y;
        a  = int'(bus.A);
        b  = int'(bus.B);
        bi = int'(bus.BorrowIN);
        d  = a - b - bi;
        yw = (d + 2 * MOD) % MOD;
        amsb = a / (MOD / 2);
        bmsb = b / (MOD / 2);
        ov = (amsb != bmsb && (yw / (MOD / 2)) != amsb) ? 1 : 0;
        y  = yw;
`ifdef SUB_SATURATE_EN
        if (ov == 1) y = (amsb == 1) ? (MOD / 2) : (MOD / 2 - 1);
`endif
        m_y     = y;
        m_bo    = (d < 0) ? 1 : 0;
        m_ovf   = ov;
        m_zero  = (y == 0) ? 1 : 0;
        m_neg   = (y >= MOD / 2) ? 1 : 0;
        m_valid = 1;
        if (ov == 1) m_sticky = 1;
        else if (bus.ovf_clr) m_sticky = 0;
      end else begin
        m_valid = 0;
        if (bus.ovf_clr) m_sticky = 0;
      end
    end
  end

  // Compare process: every falling edge while out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("cmp_y",      int'(bus.Y),          m_y);
        check("cmp_borrow", int'(bus.BorrowOUT),  m_bo);
        check("cmp_ovf",    int'(bus.overflow),   m_ovf);
        check("cmp_zero",   int'(bus.zero),       m_zero);
        check("cmp_neg",    int'(bus.negative),   m_neg);
        check("cmp_valid",  int'(bus.out_valid),  m_valid);
        check("cmp_sticky", int'(bus.ovf_sticky), m_sticky);
      end
    end
  end

  // Apply one set of inputs and return 1 time unit after the registering edge
  task automatic do_op(input int a, input int b, input int bi, input int v, input int clr);
    bus.A        = W'(a);
    bus.B        = W'(b);
    bus.BorrowIN = bi[0];
    bus.in_valid = v[0];
    bus.ovf_clr  = clr[0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int y, input int bo, input int ov,
                           input int z, input int n, input int v, input int st);
    check({tag, "_y"},      int'(bus.Y),          y);
    check({tag, "_borrow"}, int'(bus.BorrowOUT),  bo);
    check({tag, "_ovf"},    int'(bus.overflow),   ov);
    check({tag, "_zero"},   int'(bus.zero),       z);
    check({tag, "_neg"},    int'(bus.negative),   n);
    check({tag, "_valid"},  int'(bus.out_valid),  v);
    check({tag, "_sticky"}, int'(bus.ovf_sticky), st);
  endtask

  typedef struct {
    int a, b, bi, y, bo, ov, z, n, st;
  } vec_t;

  initial begin
    vec_t vecs[5];
`ifdef SUB_SATURATE_EN
    vecs[0] = '{8,  2, 1,  8, 0, 1, 0, 1, 1};
`else
    vecs[0] = '{8,  2, 1,  5, 0, 1, 0, 0, 1};
`endif
    vecs[1] = '{2,  6, 0, 12, 1, 0, 0, 1, 1};
    vecs[2] = '{12, 4, 0,  8, 0, 0, 0, 1, 1};
    vecs[3] = '{8,  8, 0,  0, 0, 0, 1, 0, 1};
    vecs[4] = '{15, 1, 1, 13, 0, 0, 0, 1, 1};

    // Asynchronous reset with live, nonzero operands
    rst_n        = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 4'hA;
    bus.B        = 4'h3;
    bus.BorrowIN = 1'b1;
    bus.ovf_clr  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_all("rst_async", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 0, 0, 1, 0);
    check_all("first_zero", 0, 0, 0, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bi, 1, 0);
      check_all($sformatf("vec%0d", i), vecs[i].y, vecs[i].bo, vecs[i].ov,
                vecs[i].z, vecs[i].n, 1, vecs[i].st);
    end

    // Clear pulse without new operation: sticky drops, results hold
    do_op(3, 9, 0, 0, 1);
    check_all("clr_hold", 13, 0, 0, 0, 1, 0, 0);

    // 0 - 0 - 1 wraps to all ones with borrow, no signed overflow
    do_op(0, 0, 1, 1, 0);
    check_all("zero_borrow", 15, 1, 0, 0, 1, 1, 0);

    // 7 - (-1): overflow coincides with clear, set wins
`ifdef SUB_SATURATE_EN
    do_op(7, 15, 0, 1, 1);
    check_all("set_wins", 7, 1, 1, 0, 0, 1, 1);
`else
    do_op(7, 15, 0, 1, 1);
    check_all("set_wins", 8, 1, 1, 0, 1, 1, 1);
`endif

    // Reset in the middle of a cycle with an operation pending
    bus.A = 4'h8; bus.B = 4'h2; bus.BorrowIN = 1'b1; bus.in_valid = 1'b1; bus.ovf_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, checked by the compare process
    for (int i = 0; i < 400; i++) begin
      do_op(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    bus.in_valid = 1'b0;
    bus.ovf_clr  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
